// File: rtl/hs_responder_fifo.sv
// Four-phase handshake responder feeding a first-word-fall-through FIFO; ack_out rises 3 edges after req_in.
// A full FIFO stalls the acknowledge until a pop frees an entry.
module hs_responder_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_in,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     ack_out,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, ACKED} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               req_meta;
    logic               req_s;
    logic               req_s_q;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic               full;
    logic               push;
    logic               pop;
    logic               withdraw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_meta <= 1'b0;
            req_s    <= 1'b0;
            req_s_q  <= 1'b0;
        end else begin
            req_meta <= req_in;
            req_s    <= req_meta;
            req_s_q  <= req_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (req_s && !full) begin
                    push      = 1'b1;
                    state_nxt = ACKED;
                end
            end
            ACKED: begin
                if (!req_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ack_out   = (state == ACKED);
    assign full      = (count == CW'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    // Request dropped while still waiting in IDLE: the initiator gave up without an ack.
    assign withdraw  = (state == IDLE) && req_s_q && !req_s;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            proto_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (withdraw) proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hs_responder_fifo.sv
// Bench for hs_responder_fifo: directed handshake/stall/withdraw/reset steps plus a randomized
// transfer phase, scored against a queue model of the FIFO contents.
module tb_hs_responder_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_in;
    logic [15:0] data_in;
    logic        ack_out;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic [2:0]  count;
    logic        proto_err;

    int checks   = 0;
    int failures = 0;
    int n;
    logic [15:0] q[$];

    hs_responder_fifo #(.DATA_W(16), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_in    (req_in),
        .data_in   (data_in),
        .ack_out   (ack_out),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock with model upkeep: a pop leaves when ready meets a non-empty queue,
    // and a word enters on the edge at which the acknowledge rises.
    task automatic step();
        logic do_pop;
        logic ack_before;
        do_pop = out_ready && (q.size() != 0);
        if (do_pop) check("head", {16'h0, out_data}, {16'h0, q[0]});
        ack_before = ack_out;
        tick();
        if (do_pop) void'(q.pop_front());
        if (!ack_before && ack_out) q.push_back(data_in);
        check("count", {29'h0, count}, q.size());
        check("valid", {31'h0, out_valid}, {31'h0, q.size() != 0});
    endtask

    // Full four-phase cycle with exact acknowledge latency; requires free space.
    task automatic xfer(input logic [15:0] d);
        req_in  = 1'b1;
        data_in = d;
        step(); step();
        check("ack_rise_early", {31'h0, ack_out}, 32'h0);
        step();
        check("ack_rise_3", {31'h0, ack_out}, 32'h1);
        req_in = 1'b0;
        step(); step();
        check("ack_fall_early", {31'h0, ack_out}, 32'h1);
        step();
        check("ack_fall_3", {31'h0, ack_out}, 32'h0);
    endtask

    initial begin
        reset     = 1'b1;
        req_in    = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        tick(); tick();
        check("rst_ack",   {31'h0, ack_out},   32'h0);
        check("rst_count", {29'h0, count},     32'h0);
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_perr",  {31'h0, proto_err}, 32'h0);
        reset = 1'b0;

        // Single transfer
        xfer(16'hA5A5);
        check("single_data", {16'h0, out_data}, 32'hA5A5);
        check("single_count", {29'h0, count}, 32'h1);

        // Drain, then ready on empty FIFO must be ignored
        out_ready = 1'b1;
        step(); step(); step();
        out_ready = 1'b0;

        // Fill and stall
        for (int i = 1; i <= 4; i++) xfer(16'(i));
        check("fill_count", {29'h0, count}, 32'h4);
        req_in  = 1'b1;
        data_in = 16'h0005;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_ack", {31'h0, ack_out}, 32'h0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("stall_pop_ack", {31'h0, ack_out}, 32'h0);
        check("stall_pop_count", {29'h0, count}, 32'h3);
        step();
        check("stall_release_ack", {31'h0, ack_out}, 32'h1);
        check("stall_release_count", {29'h0, count}, 32'h4);
        check("stall_head", {16'h0, out_data}, 32'h2);
        req_in = 1'b0;
        n = 0;
        while (ack_out !== 1'b0 && n < 10) begin step(); n++; end
        check("stall_ack_fall", {31'h0, ack_out}, 32'h0);

        // Withdrawn request while full
        check("pre_withdraw_perr", {31'h0, proto_err}, 32'h0);
        req_in  = 1'b1;
        data_in = 16'($urandom);
        for (int i = 0; i < 5; i++) step();
        check("withdraw_ack", {31'h0, ack_out}, 32'h0);
        req_in = 1'b0;
        step(); step(); step();
        check("withdraw_perr", {31'h0, proto_err}, 32'h1);
        check("withdraw_count", {29'h0, count}, 32'h4);
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 10) begin step(); n++; end
        out_ready = 1'b0;
        check("withdraw_drained", {29'h0, count}, 32'h0);
        check("perr_sticky", {31'h0, proto_err}, 32'h1);

        // Simultaneous push and pop at count 2
        xfer(16'($urandom));
        xfer(16'($urandom));
        req_in  = 1'b1;
        data_in = 16'($urandom);
        step(); step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pushpop_ack", {31'h0, ack_out}, 32'h1);
        check("pushpop_count", {29'h0, count}, 32'h2);
        req_in = 1'b0;
        n = 0;
        while (ack_out !== 1'b0 && n < 10) begin step(); n++; end
        check("pushpop_ack_fall", {31'h0, ack_out}, 32'h0);

        // Randomized consumer over 10 transfers with pointer wrap
        for (int i = 0; i < 10; i++) begin
            req_in  = 1'b1;
            data_in = {8'($urandom), 8'(i + 1)};
            n = 0;
            while (ack_out !== 1'b1 && n < 30) begin
                out_ready = 1'($urandom_range(0, 1));
                step(); n++;
            end
            check("rand_ack_rise", {31'h0, ack_out}, 32'h1);
            req_in = 1'b0;
            n = 0;
            while (ack_out !== 1'b0 && n < 30) begin
                out_ready = 1'($urandom_range(0, 1));
                step(); n++;
            end
            check("rand_ack_fall", {31'h0, ack_out}, 32'h0);
        end
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 20) begin step(); n++; end
        out_ready = 1'b0;
        check("rand_drained", {29'h0, count}, 32'h0);

        // Reset in the middle of an acknowledged handshake
        xfer(16'h1111);
        xfer(16'h2222);
        req_in  = 1'b1;
        data_in = 16'h0C0C;
        n = 0;
        while (ack_out !== 1'b1 && n < 10) begin step(); n++; end
        check("pre_rst_count", {29'h0, count}, 32'h3);
        reset = 1'b1;
        #1;
        check("midrst_ack",   {31'h0, ack_out},   32'h0);
        check("midrst_count", {29'h0, count},     32'h0);
        check("midrst_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_perr",  {31'h0, proto_err}, 32'h0);
        q.delete();
        tick();
        reset = 1'b0;
        step(); step();
        check("post_rst_ack_early", {31'h0, ack_out}, 32'h0);
        step();
        check("post_rst_ack", {31'h0, ack_out}, 32'h1);
        check("post_rst_count", {29'h0, count}, 32'h1);
        check("post_rst_data", {16'h0, out_data}, 32'h0C0C);
        req_in = 1'b0;
        n = 0;
        while (ack_out !== 1'b0 && n < 10) begin step(); n++; end
        check("post_rst_ack_fall", {31'h0, ack_out}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
